// File: rtl/y86_inst_encoder_pkg.sv
// rtl/y86_inst_encoder_pkg.sv - shared Y86-64 icode, register and length constants
package y86_inst_encoder_pkg;

    localparam int WORD = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] LEN_1  = 4'd1;
    localparam logic [3:0] LEN_2  = 4'd2;
    localparam logic [3:0] LEN_9  = 4'd9;
    localparam logic [3:0] LEN_10 = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_REG,
        S_CONST
    } enc_state_t;

endpackage

// File: rtl/y86_inst_len.sv
// rtl/y86_inst_len.sv - icode to instruction length and byte-group presence
module y86_inst_len
    import y86_inst_encoder_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       need_reg,
    output logic       need_const,
    output logic       invalid
);

    always_comb begin
        len        = 4'd0;
        need_reg   = 1'b0;
        need_const = 1'b0;
        invalid    = 1'b0;
        case (icode)
            IHALT, INOP, IRET: len = LEN_1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
                len      = LEN_2;
                need_reg = 1'b1;
            end
            IJXX, ICALL: begin
                len        = LEN_9;
                need_const = 1'b1;
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                len        = LEN_10;
                need_reg   = 1'b1;
                need_const = 1'b1;
            end
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/y86_inst_encoder.sv
// rtl/y86_inst_encoder.sv - Y86-64 instruction field to byte-stream encoder
// Optional field canonicalisation at accept: ENC_CANON_EN
module y86_inst_encoder
    import y86_inst_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [WORD-1:0]   valC,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_byte,
    output logic              inst_done,
    output logic [3:0]        inst_len,
    output logic              err,
    output logic [ADDR_W-1:0] pc
);

    enc_state_t state, state_n;

    logic [3:0]      icode_q, ifun_q, ra_q, rb_q, len_q;
    logic [WORD-1:0] valc_q;
    logic [2:0]      cnt;
    logic            need_reg_q, need_const_q;

    logic [3:0] len_in;
    logic       need_reg_in, need_const_in, invalid_in;
    logic [3:0] c_ifun, c_ra, c_rb;
    logic       accept, finish, fire;

    y86_inst_len u_len (
        .icode      (icode),
        .len        (len_in),
        .need_reg   (need_reg_in),
        .need_const (need_const_in),
        .invalid    (invalid_in)
    );

    always_comb begin
`ifdef ENC_CANON_EN
        c_ifun = ifun;
        c_ra   = rA;
        c_rb   = rB;
        if (icode == IIRMOVQ)
            c_ra = RNONE;
        if (icode == IPUSHQ || icode == IPOPQ)
            c_rb = RNONE;
        if (!(icode == IRRMOVQ || icode == IOPQ || icode == IJXX))
            c_ifun = 4'h0;
`else
        c_ifun = ifun;
        c_ra   = rA;
        c_rb   = rB;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                // A pending PC load blocks the accept for this cycle
                in_ready = !pc_load;
                if (in_valid && !pc_load) begin
                    accept = 1'b1;
                    if (!invalid_in)
                        state_n = S_HDR;
                end
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_byte  = {icode_q, ifun_q};
                if (out_ready) begin
                    if (need_reg_q)
                        state_n = S_REG;
                    else if (need_const_q)
                        state_n = S_CONST;
                    else begin
                        state_n = S_IDLE;
                        finish  = 1'b1;
                    end
                end
            end
            S_REG: begin
                out_valid = 1'b1;
                out_byte  = {ra_q, rb_q};
                if (out_ready) begin
                    if (need_const_q)
                        state_n = S_CONST;
                    else begin
                        state_n = S_IDLE;
                        finish  = 1'b1;
                    end
                end
            end
            S_CONST: begin
                out_valid = 1'b1;
                out_byte  = valc_q[{cnt, 3'b000} +: 8];
                if (out_ready && cnt == 3'd7) begin
                    state_n = S_IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign fire     = out_valid && out_ready;
    assign out_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= BASE_ADDR;
            icode_q      <= 4'h0;
            ifun_q       <= 4'h0;
            ra_q         <= 4'h0;
            rb_q         <= 4'h0;
            len_q        <= 4'h0;
            valc_q       <= '0;
            need_reg_q   <= 1'b0;
            need_const_q <= 1'b0;
            cnt          <= 3'd0;
            inst_done    <= 1'b0;
            inst_len     <= 4'h0;
            err          <= 1'b0;
        end else begin
            inst_done <= finish;
            err       <= accept && invalid_in;
            if (finish)
                inst_len <= len_q;
            if (state == S_IDLE && pc_load)
                pc <= load_addr;
            else if (fire)
                pc <= pc + ADDR_W'(1);
            if (accept) begin
                icode_q      <= icode;
                ifun_q       <= c_ifun;
                ra_q         <= c_ra;
                rb_q         <= c_rb;
                valc_q       <= valC;
                len_q        <= len_in;
                need_reg_q   <= need_reg_in;
                need_const_q <= need_const_in;
                cnt          <= 3'd0;
            end else if (fire && state == S_CONST) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_y86_inst_encoder.sv
// tb/tb_y86_inst_encoder.sv - scoreboard bench for y86_inst_encoder
module tb_y86_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_load;
    logic [63:0] load_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_addr;
    logic [7:0]  out_byte;
    logic        inst_done;
    logic [3:0]  inst_len;
    logic        err;
    logic [63:0] pc;

    y86_inst_encoder #(.ADDR_W(64), .BASE_ADDR(64'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_load   (pc_load),
        .load_addr (load_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_byte  (out_byte),
        .inst_done (inst_done),
        .inst_len  (inst_len),
        .err       (err),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [71:0] exp_q[$];
    int          len_q[$];
    int          err_pend = 0;
    logic [63:0] mpc = 64'h0;
    int          rdy_mode = 1;
    int          len_tbl[12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference: byte image from the architectural encoding rules
    task automatic push_inst(input logic [3:0] ic, input logic [3:0] fn,
                             input logic [3:0] a, input logic [3:0] b, input logic [63:0] c);
        int len;
        logic [7:0] bytes[$];
        if (ic >= 4'hC) begin
            err_pend++;
            return;
        end
`ifdef ENC_CANON_EN
        if (ic == 4'h3) a = 4'hF;
        if (ic == 4'hA || ic == 4'hB) b = 4'hF;
        if (ic != 4'h2 && ic != 4'h6 && ic != 4'h7) fn = 4'h0;
`endif
        len = len_tbl[ic];
        bytes.push_back({ic, fn});
        if (len == 2 || len == 10) bytes.push_back({a, b});
        if (len >= 9)
            for (int k = 0; k < 8; k++) bytes.push_back(8'(c >> (8 * k)));
        foreach (bytes[i]) begin
            exp_q.push_back({mpc, bytes[i]});
            mpc = mpc + 64'd1;
        end
        len_q.push_back(len);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b1;
            2: out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    logic        stall_prev = 1'b0;
    logic [7:0]  sb;
    logic [63:0] sa;
    logic [71:0] e;
    int          el;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_byte", out_byte, sb);
                chk("stall_addr", out_addr, sa);
            end
            stall_prev = out_valid && !out_ready;
            sb = out_byte;
            sa = out_addr;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) flag("unexpected_byte");
                else begin
                    e = exp_q.pop_front();
                    chk("byte", out_byte, e[7:0]);
                    chk("addr", out_addr, e[71:8]);
                end
            end
            if (inst_done) begin
                if (len_q.size() == 0) flag("unexpected_inst_done");
                else begin
                    el = len_q.pop_front();
                    chk("inst_len", inst_len, el);
                end
            end
            if (err) begin
                if (err_pend == 0) flag("unexpected_err");
                else err_pend--;
            end
        end
    end

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] c, input bit keep,
                        output bit done_at_acc);
        int n = 0;
        done_at_acc = 1'b0;
        icode = ic; ifun = fn; rA = a; rB = b; valC = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) flag("accept_timeout");
        else begin
            done_at_acc = inst_done;
            push_inst(ic, fn, a, b, c);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) flag("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    bit          d;
    logic [63:0] start, pc_before;

    initial begin
        rst = 1'b1; pc_load = 1'b0; load_addr = '0; in_valid = 1'b0;
        icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF; valC = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_out_addr", out_addr, 64'h0);
        chk("rst_pc", pc, 64'h0);
        chk("rst_inst_done", inst_done, 1'b0);
        chk("rst_inst_len", inst_len, 4'h0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // irmovq full speed
        rdy_mode = 1;
        send(4'h3, 4'h0, 4'hF, 4'h0, 64'h0123456789ABCDEF, 1'b0, d);
        drain();
        chk("irmovq_pc", pc, 64'd10);

        // call with toggling ready
        rdy_mode = 2;
        send(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 1'b0, d);
        drain();

        // back-to-back pushq, halt, ret
        rdy_mode = 1;
        send(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 1'b1, d);
        send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b1, d);
        chk("b2b_halt_in_done_cycle", d, 1'b1);
        send(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0, d);
        chk("b2b_ret_in_done_cycle", d, 1'b1);
        drain();

        // pc_load beats in_valid, then wrap
        icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
        in_valid = 1'b1; pc_load = 1'b1; load_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("load_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        pc_load = 1'b0;
        chk("load_pc", pc, 64'hFFFF_FFFF_FFFF_FFFF);
        mpc = 64'hFFFF_FFFF_FFFF_FFFF;
        send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0, d);
        send(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 1'b0, d);
        drain();
        chk("wrap_pc", pc, 64'd2);

        // invalid icode
        pc_before = pc;
        send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, d);
        chk("err_pulse", err, 1'b1);
        chk("err_no_valid", out_valid, 1'b0);
        chk("err_pc", pc, pc_before);
        @(posedge clk);
        #1;
        chk("err_one_cycle", err, 1'b0);

        // reset while emitting CONST byte 3
        start = mpc;
        send(4'h3, 4'h0, 4'hF, 4'h1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, d);
        begin
            int n = 0;
            while (!(out_valid && out_addr == start + 64'd4) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) flag("reach_const3_timeout");
        end
        rdy_mode = 3;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_pc", pc, 64'h0);
        chk("midrst_out_addr", out_addr, 64'h0);
        exp_q.delete();
        len_q.delete();
        mpc = 64'h0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);

        // pushq with non-canonical fields
        rdy_mode = 1;
        send(4'hA, 4'h2, 4'h3, 4'h5, 64'h0, 1'b0, d);
        drain();

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            rdy_mode = ($urandom_range(0, 4) == 0) ? 2 : 0;
            send(4'($urandom_range(0, 13)), 4'($urandom), 4'($urandom), 4'($urandom),
                 {$urandom, $urandom}, bit'($urandom_range(0, 1)), d);
        end
        rdy_mode = 1;
        in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("final_pc", pc, mpc);
        chk("final_err_pend", err_pend, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/y86_inst_encoder.md
Name: y86_inst_encoder

Overview:
Encoder counterpart to the SEQ fetch stage. It accepts decoded Y86-64 instruction fields (icode, ifun, rA, rB, valC) and serialises them into the architectural variable-length byte stream, one byte per cycle, with the little-endian constant. Each byte is presented with its instruction-memory address. It sits between the test/loader front end and the instruction memory write port and produces exactly the images the fetch stage decodes.

Parameters:
ADDR_W, 64, width of the byte address / PC counter
BASE_ADDR, 64'h0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_load  in  1  load PC from load_addr; honoured only in IDLE
load_addr  in  ADDR_W  new PC value
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept an instruction
icode  in  4  instruction code
ifun  in  4  function code
rA  in  4  register A
rB  in  4  register B
valC  in  64  constant / displacement / destination
out_valid  out  1  byte valid
out_ready  in  1  memory accepts byte
out_addr  out  ADDR_W  byte address (current PC)
out_byte  out  8  encoded byte
inst_done  out  1  one-cycle pulse after the last byte of an instruction is accepted
inst_len  out  4  length of the instruction just completed; valid with inst_done
err  out  1  one-cycle pulse: invalid icode (>= 4'hC) consumed, nothing emitted
pc  out  ADDR_W  next free address

Behaviour:
- Reset (async): state IDLE, pc=BASE_ADDR, out_valid=0, out_byte=0, out_addr=BASE_ADDR, inst_done=0, inst_len=0, err=0. Reset mid-instruction abandons the remaining bytes. Bytes already accepted stay in memory.
- in_ready = (state==IDLE) && !pc_load. pc_load wins over in_valid in the same cycle. pc updates next edge.
- Accept on in_valid && in_ready. All fields are latched. in_valid is ignored outside IDLE.
- States: IDLE -> HDR -> [REG] -> [CONST x8] -> IDLE. A state advances only on out_valid && out_ready. out_byte and out_addr hold stable while stalled.
- HDR byte = {icode, ifun}.
- REG byte = {rA, rB}. Emitted for icodes 2, 3, 4, 5, 6, A, B.
- CONST: valC bytes 7:0 first, then up to 63:56, via a 3-bit byte counter. Emitted for icodes 3, 4, 5, 7, 8.
- Lengths: icodes 0, 1, 9 give 1; icodes 2, 6, A, B give 2; icodes 7, 8 give 9; icodes 3, 4, 5 give 10.
- pc increments by 1 on every accepted byte. out_addr = pc. Wraps modulo 2^ADDR_W.
- inst_done/inst_len are registered and assert the cycle after the final byte handshake. The next instruction may be accepted in that same cycle.
- Invalid icode: accepted, err pulses the next cycle, state stays IDLE, pc unchanged, no inst_done.
- out_valid is high exactly in HDR, REG and CONST.

Optional Feature:
ENC_CANON_EN:
- Defined: fields are canonicalised at accept.
  - rA forced to 4'hF for irmovq.
  - rB forced to 4'hF for pushq and popq.
  - ifun forced to 0 for every icode except 2, 6, 7.
- Undefined: fields are emitted exactly as supplied.

Decomposition:
- Shared defines header holds:
  - icode constants (INOP, IHALT, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ)
  - RNONE = 4'hF
  - instruction length constants
  - the WORD bus width
- One natural sub-module: y86_inst_len.
  - Combinational: icode -> {len, need_reg, need_const, invalid}.
  - Reusable by the fetch stage for its valP computation.

Test Plan:
- irmovq $0x0123456789ABCDEF,%rax at PC 0, out_ready=1 -> bytes 30 F0 EF CD AB 89 67 45 23 01 at addr 0..9; inst_done with inst_len=10; pc=10.
- call 0x100 with out_ready toggling 1/0 every cycle -> bytes 80 00 01 00 00 00 00 00 00 with no duplicates or drops; out_byte stable during stalls; inst_len=9.
- Back-to-back pushq %rbx (A0 3F), halt (00), ret (90) with in_valid held high -> 4 contiguous bytes at consecutive addresses; new accept in the inst_done cycle.
- pc_load with load_addr=64'hFFFF_FFFF_FFFF_FFFF asserted together with in_valid, then nop and rrmovq %rcx,%rdx -> load wins; 10 at FFFF...FF; 20 12 at addresses 0 and 1 (wrap).
- icode=4'hC -> err pulse, no out_valid, pc unchanged. Then assert rst during CONST byte 3 of an irmovq -> out_valid drops immediately, pc=BASE_ADDR, in_ready=1 after release.
- ENC_CANON_EN defined: pushq rA=3, rB=5, ifun=2 -> bytes A0 3F. Undefined -> A2 35.
